// File: rtl/key_expander.sv
// key_expander: sequential AES-128/192/256 key schedule generator with registered round-key read port
module sub_word (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254) followed by the AES affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
endmodule

module key_expander #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         keys_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_data
);
    localparam int TOTAL = MAX_KEY_BITS == 128 ? 44 : MAX_KEY_BITS == 192 ? 52 : 60;
    localparam logic S_IDLE   = 1'b0;
    localparam logic S_EXPAND = 1'b1;

    logic         state_q, state_d;
    logic [1:0]   mode_q, mode_d;
    logic [5:0]   i_q, i_d;
    logic [2:0]   j_q, j_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  win_q [8];
    logic [31:0]  win_d [8];
    logic         busy_q, busy_d, done_q, done_d, err_q, err_d, kv_q, kv_d;
    logic [127:0] rk_q, rk_d;
    logic [31:0]  mem_q [TOTAL];
    logic [3:0]   nk, nk_in, nr, ri;
    logic [5:0]   last, base;
    logic         legal, load, step;
    logic [31:0]  prev, sub_in, sub_out, t, new_w;

    sub_word u_sub (.din(sub_in), .dout(sub_out));

    // Decode key size and compute the next schedule word; j_q tracks i mod Nk
    always_comb begin
        nk     = mode_q == 2'd0 ? 4'd4 : mode_q == 2'd1 ? 4'd6 : 4'd8;
        nk_in  = mode == 2'd0 ? 4'd4 : mode == 2'd1 ? 4'd6 : 4'd8;
        nr     = nk + 4'd6;
        last   = mode_q == 2'd0 ? 6'd43 : mode_q == 2'd1 ? 6'd51 : 6'd59;
        legal  = mode == 2'd0 || (mode == 2'd1 && MAX_KEY_BITS >= 192) || (mode == 2'd2 && MAX_KEY_BITS >= 256);
        load   = state_q == S_IDLE && start && legal;
        step   = state_q == S_EXPAND;
        prev   = win_q[3'(nk - 4'd1)];
        sub_in = j_q == 3'd0 ? {prev[7:0], prev[31:8]} : prev;
        t      = j_q == 3'd0 ? sub_out ^ {24'h0, rcon_q} : (nk == 4'd8 && j_q == 3'd4) ? sub_out : prev;
        new_w  = win_q[0] ^ t;
        ri     = rk_idx > nr ? 4'd0 : rk_idx;
        base   = {ri, 2'b00};
    end

    // Next-state logic for the expansion FSM, sliding window and read port
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        win_d   = win_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        kv_d    = kv_q;
        rk_d    = rk_idx > nr ? 128'h0 : {mem_q[base + 6'd3], mem_q[base + 6'd2], mem_q[base + 6'd1], mem_q[base]};
        if (load) begin
            state_d = S_EXPAND;
            mode_d  = mode;
            i_d     = {2'b00, nk_in};
            j_d     = 3'd0;
            rcon_d  = 8'h01;
            busy_d  = 1'b1;
            kv_d    = 1'b0;
            for (int k = 0; k < 8; k++) win_d[k] = key_in[32*k +: 32];
        end else if (state_q == S_IDLE && start) begin
            err_d = 1'b1;
        end
        if (step) begin
            for (int k = 0; k < 7; k++) win_d[k] = win_q[k+1];
            win_d[3'(nk - 4'd1)] = new_w;
            i_d = i_q + 6'd1;
            j_d = {1'b0, j_q} == nk - 4'd1 ? 3'd0 : j_q + 3'd1;
            if (j_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            if (i_q == last) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                kv_d    = 1'b1;
            end
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            i_q     <= 6'd0;
            j_q     <= 3'd0;
            rcon_q  <= 8'h01;
            win_q   <= '{default: 32'h0};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            kv_q    <= 1'b0;
            rk_q    <= 128'h0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            win_q   <= win_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            kv_q    <= kv_d;
            rk_q    <= rk_d;
        end
    end

    // Round-key store: key words on load, one expanded word per cycle afterwards
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 8; k++)
                if (k < int'(nk_in)) mem_q[k] <= key_in[32*k +: 32];
        end else if (step) begin
            mem_q[i_q] <= new_w;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign keys_valid = kv_q;
    assign rk_data    = rk_q;
endmodule

// File: tb/tb_key_expander.sv
// tb_key_expander: known-answer vectors plus randomized keys against a byte-level AES key schedule model
module tb_key_expander;
    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
    logic [1:0]   mode = 2'd0, mode2 = 2'd0;
    logic [255:0] key_in = '0;
    logic [3:0]   rk_idx = 4'd0;
    logic         busy, done, err, kv, busy2, done2, err2, kv2;
    logic [127:0] rk_data, rk2;
    int           n_cmp = 0, n_bad = 0;
    logic [7:0]   sb [256];
    logic [31:0]  mw [60];

    always #5 clk = ~clk;

    key_expander #(.MAX_KEY_BITS(256)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in), .busy(busy), .done(done),
        .err(err), .keys_valid(kv), .rk_idx(rk_idx), .rk_data(rk_data));

    key_expander #(.MAX_KEY_BITS(128)) dut128 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .key_in(key_in), .busy(busy2), .done(done2),
        .err(err2), .keys_valid(kv2), .rk_idx(rk_idx), .rk_data(rk2));

    typedef struct {
        logic [1:0]   m;
        logic [255:0] kbe;
        int           r;
        int           w;
        logic [31:0]  ebe;
    } vec_t;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        logic [7:0] c63 = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) if (gm(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sb[a] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic model(input logic [1:0] m, input logic [255:0] kle);
        logic [7:0]  rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        int          nk = 4 + 2 * int'(m);
        int          tot = 4 * (nk + 7);
        logic [31:0] t;
        for (int i = 0; i < nk; i++) mw[i] = kle[32*i +: 32];
        for (int i = nk; i < tot; i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t = subw({t[7:0], t[31:8]});
                t[7:0] ^= rc[i/nk-1];
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic expand(input logic [1:0] m, input logic [255:0] kle, input bit mid, output int n);
        bit err_seen = 0;
        mode = m;
        key_in = kle;
        start = 1'b1;
        @(posedge clk); #1;
        if (mid) begin
            mode = 2'b11;
            key_in = {8{$urandom}};
        end else start = 1'b0;
        chk("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (mid && n == 3) start = 1'b0;
            if (err) err_seen = 1;
        end
        chk("expand_cycles", n, 40 + 6 * int'(m));
        chk("kv_after_done", kv, 1);
        chk("busy_after_done", busy, 0);
        if (mid) chk("no_err_in_expand", err_seen, 0);
    endtask

    task automatic full_check(input logic [1:0] m, input logic [255:0] kle, input string tag);
        int nr = 10 + 2 * int'(m);
        logic [127:0] exp;
        model(m, kle);
        for (int r = 0; r < 16; r++) begin
            rk_idx = 4'(r);
            @(posedge clk); #1;
            exp = r <= nr ? {mw[4*r+3], mw[4*r+2], mw[4*r+1], mw[4*r]} : 128'h0;
            chk($sformatf("%s_rk%0d", tag, r), rk_data, exp);
        end
    endtask

    initial begin
        vec_t tbl[14];
        logic [255:0] kle, ka, kb;
        logic [31:0] e32;
        logic [1:0] cur, ma, mb;
        int n;
        bit seen;
        tbl = '{
            '{2'd0, K128, 1, 0, 32'ha0fafe17}, '{2'd0, K128, 1, 1, 32'h88542cb1},
            '{2'd0, K128, 1, 2, 32'h23a33939}, '{2'd0, K128, 1, 3, 32'h2a6c7605},
            '{2'd0, K128, 10, 0, 32'hd014f9a8}, '{2'd0, K128, 10, 1, 32'hc9ee2589},
            '{2'd0, K128, 10, 2, 32'he13f0cc8}, '{2'd0, K128, 10, 3, 32'hb6630ca6},
            '{2'd1, K192, 1, 2, 32'hfe0c91f7}, '{2'd1, K192, 12, 3, 32'h01002202},
            '{2'd1, K192, 0, 0, 32'h8e73b0f7}, '{2'd2, K256, 2, 0, 32'h9ba35411},
            '{2'd2, K256, 14, 3, 32'h706c631e}, '{2'd2, K256, 1, 3, 32'h0914dff4}};
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_kv", kv, 0);
        chk("reset_rk", rk_data, 0);
        rst = 1'b0;

        cur = 2'b11;
        for (int v = 0; v < 14; v++) begin
            if (tbl[v].m != cur) begin
                kle = {<<8{tbl[v].kbe}};
                expand(tbl[v].m, kle, 0, n);
                if (v == 0) begin
                    @(posedge clk); #1;
                    chk("done_one_cycle", done, 0);
                end
                cur = tbl[v].m;
            end
            rk_idx = 4'(tbl[v].r);
            @(posedge clk); #1;
            e32 = {<<8{tbl[v].ebe}};
            chk($sformatf("kat_m%0d_r%0d_w%0d", tbl[v].m, tbl[v].r, tbl[v].w), rk_data[32*tbl[v].w +: 32], e32);
        end
        kle = {<<8{K256}};
        full_check(2'd2, kle, "aes256");

        mode = 2'b11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        chk("rej_kv", kv, 1);
        @(posedge clk); #1;
        chk("rej_err_pulse", err, 0);
        full_check(2'd2, kle, "after_rej");

        kle = {<<8{K128}};
        expand(2'd0, kle, 0, n);
        full_check(2'd0, kle, "aes128");

        mode2 = 2'd2;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("max128_err", err2, 1);
        chk("max128_busy", busy2, 0);
        mode2 = 2'd0;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("max128_accept", busy2, 1);
        chk("max128_no_err", err2, 0);

        for (int it = 0; it < 3; it++) begin
            ma = 2'($urandom_range(0, 2));
            mb = 2'($urandom_range(0, 2));
            ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            expand(ma, ka, it == 1, n);
            expand(mb, kb, 0, n);
            full_check(mb, kb, $sformatf("rand%0d", it));
        end

        kle = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mode = 2'd0;
        key_in = kle;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_kv", kv, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("rst_mid_no_done", seen, 0);
        expand(2'd1, kle, 0, n);
        full_check(2'd1, kle, "rekey");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
